deserializer_frame_arbiter: RTL and testbench
=============================================

Name: deserializer_frame_arbiter

Overview:
- Shares one deserializer input port between N_REQ independent val/rdy sample streams.
- Locks the grant to one requester for a whole frame of N_SAMPLES beats, so the deserializer only ever assembles samples from a single source.
- Between frames, picks the next owner round-robin.
- Sits directly upstream of the deserializer; send_* connects to the deserializer's recv_* port.

Parameters:
- N_REQ, 4, number of requesters; legal range ≥2.
- N_SAMPLES, 8, beats per frame; must equal the downstream deserializer's N_SAMPLES; legal range ≥2.
- BIT_WIDTH, 32, sample width in bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- recv_val  in  N_REQ  per-requester valid.
- recv_rdy  out  N_REQ  per-requester ready.
- recv_msg  in  N_REQ*BIT_WIDTH  flattened samples; requester i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
- send_val  out  1  valid to the deserializer.
- send_rdy  in  1  ready from the deserializer.
- send_msg  out  BIT_WIDTH  forwarded sample.
- grant_id  out  $clog2(N_REQ)  current or last owner.
- frame_active  out  1  high while a frame is locked.

Behaviour:
- Registered state: state (IDLE, LOCKED), grant_id, beat count ($clog2(N_SAMPLES) bits), rr_ptr ($clog2(N_REQ) bits).
- Reset (reset=0, async): state=IDLE, count=0, rr_ptr=0, grant_id=0.
  - All outputs are combinational from state, so during reset: send_val=0, recv_rdy=0, frame_active=0, send_msg=recv_msg[0].
- Priority scan: winner is the first index with recv_val=1, searching rr_ptr, rr_ptr+1, … modulo N_REQ.
- IDLE:
  - All recv_rdy=0, send_val=0, frame_active=0.
  - If any recv_val=1: grant_id <= winner, count <= 0, state <= LOCKED.
  - Otherwise stay in IDLE.
  - Arbitration costs exactly one bubble cycle; no data moves in IDLE.
- LOCKED (g = grant_id):
  - frame_active=1.
  - send_val = recv_val[g]; send_msg = recv_msg[g].
  - recv_rdy[g] = send_rdy; every other recv_rdy=0.
  - A transfer is recv_val[g] & send_rdy. On a transfer, count increments.
  - On a transfer with count == N_SAMPLES-1: count <= 0, rr_ptr <= (g+1) mod N_REQ, state <= IDLE.
  - No transfer: all state holds. A requester may drop val mid-frame; the lock is kept indefinitely and other requesters are never served until the frame completes.
- Wrap-around: rr_ptr and the scan wrap modulo N_REQ, including non-power-of-two N_REQ.
- Simultaneous requests: resolved only by the scan from rr_ptr; never by fixed priority.
- grant_id holds its value in IDLE until the next grant.
- Reset mid-frame: the partial frame is discarded and arbitration restarts at requester 0. The downstream deserializer must share the same reset so its beat count stays aligned.
- The block is combinational from send_rdy to recv_rdy[g] and from recv_val[g] to send_val; it has no storage on the data path.

Optional Feature:
- Macro: DESER_ARB_BACK_TO_BACK_EN.
- Defined: on the final-beat transfer in LOCKED, the next winner is computed from the new round-robin start (g+1) mod N_REQ.
  - If a winner exists, state stays LOCKED, grant_id <= winner, count <= 0, rr_ptr <= (g+1) mod N_REQ.
  - Consecutive frames then stream with zero bubble cycles.
  - If no requester is valid, the block goes to IDLE as normal.
- Undefined: exactly one IDLE cycle always separates frames.

Test Plan:
1. Reset, then only recv_val[2]=1 with samples 0x100..0x107 and send_rdy=1 → one IDLE cycle, then grant_id=2, frame_active=1, eight consecutive send_msg 0x100..0x107, only recv_rdy[2] high, then IDLE; rr_ptr=3.
2. All four requesters valid continuously, send_rdy=1 → frames granted in order 0,1,2,3,0; each frame is exactly 8 transfers; no beat from a non-owner ever appears on send_msg.
3. Requester 1 owns the frame; send_rdy alternates 1/0 → exactly 8 transfers, no duplicated or dropped samples, count holds on stall cycles.
4. Requester 1 owns the frame and drops recv_val after beat 3 for 5 cycles while requester 3 is valid → send_val=0, recv_rdy[3]=0 throughout; beats 4–7 resume from requester 1.
5. reset pulled to 0 asynchronously at beat 5 of a frame owned by requester 2 → outputs drop immediately (send_val=0, recv_rdy=0, frame_active=0); after release, requesters 0 and 2 both valid → requester 0 is granted.
6. Requesters 0 and 1 continuously valid → without DESER_ARB_BACK_TO_BACK_EN, frame_active has a 1-cycle low gap between frames; with it defined, frame_active stays high and requester 1's first beat transfers the cycle after requester 0's last beat.

Source files
------------

// File: rtl/deserializer_frame_arbiter.sv
// Round-robin arbiter that locks one val/rdy requester onto a deserializer for a full frame.
// Optional zero-bubble frame chaining: define DESER_ARB_BACK_TO_BACK_EN.
module deserializer_frame_arbiter #(
    parameter int N_REQ     = 4,
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             recv_val,
    output logic [N_REQ-1:0]             recv_rdy,
    input  logic [N_REQ*BIT_WIDTH-1:0]   recv_msg,
    output logic                         send_val,
    input  logic                         send_rdy,
    output logic [BIT_WIDTH-1:0]         send_msg,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         frame_active
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(N_SAMPLES);
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_SAMPLES - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_n;
    logic [GW-1:0]   grant_n;
    logic [GW-1:0]   rr_ptr, rr_n;
    logic [CW-1:0]   count, count_n;
    logic [GW-1:0]   next_ptr;
    logic [GW:0]     scan_idle;
    logic            xfer;

    // Returns {found, index} of the first valid requester at or after start, wrapping mod N_REQ.
    function automatic logic [GW:0] rr_scan(input logic [GW-1:0] start,
                                            input logic [N_REQ-1:0] val);
        logic [GW:0] result;
        int          idx;
        result = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N_REQ;
            if (val[idx]) result = {1'b1, GW'(idx)};
        end
        return result;
    endfunction

    assign scan_idle = rr_scan(rr_ptr, recv_val);
    assign next_ptr  = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + GW'(1);

`ifdef DESER_ARB_BACK_TO_BACK_EN
    logic [GW:0] scan_b2b;
    assign scan_b2b = rr_scan(next_ptr, recv_val);
`endif

    // Handshake: a beat moves on a cycle where the owner's recv_val and send_rdy are both high;
    // recv_rdy[g] mirrors send_rdy combinationally and val may drop at any time without losing the lock.
    assign xfer     = (state == LOCKED) && recv_val[grant_id] && send_rdy;
    assign send_msg = recv_msg[int'(grant_id)*BIT_WIDTH +: BIT_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_id <= '0;
            count    <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_n;
            grant_id <= grant_n;
            count    <= count_n;
            rr_ptr   <= rr_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant_id;
        count_n      = count;
        rr_n         = rr_ptr;
        send_val     = 1'b0;
        recv_rdy     = '0;
        frame_active = 1'b0;
        case (state)
            IDLE: begin
                if (scan_idle[GW]) begin
                    grant_n = scan_idle[GW-1:0];
                    count_n = '0;
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                frame_active       = 1'b1;
                send_val           = recv_val[grant_id];
                recv_rdy[grant_id] = send_rdy;
                if (xfer) begin
                    if (count == LAST_BEAT) begin
                        count_n = '0;
                        rr_n    = next_ptr;
                        state_n = IDLE;
`ifdef DESER_ARB_BACK_TO_BACK_EN
                        if (scan_b2b[GW]) begin
                            grant_n = scan_b2b[GW-1:0];
                            state_n = LOCKED;
                        end
`endif
                    end else begin
                        count_n = count + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_deserializer_frame_arbiter.sv
// Self-checking bench for deserializer_frame_arbiter: directed table, corner sequences and
// randomized traffic against a frame-level reference model.
module tb_deserializer_frame_arbiter;

    localparam int N_REQ     = 4;
    localparam int N_SAMPLES = 8;
    localparam int BW        = 32;
`ifdef DESER_ARB_BACK_TO_BACK_EN
    localparam int FRAME_GAP = 1;
`else
    localparam int FRAME_GAP = 2;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        recv_val;
    logic [N_REQ-1:0]        recv_rdy;
    logic [N_REQ*BW-1:0]     recv_msg;
    logic                    send_val;
    logic                    send_rdy;
    logic [BW-1:0]           send_msg;
    logic [1:0]              grant_id;
    logic                    frame_active;

    deserializer_frame_arbiter #(
        .N_REQ(N_REQ), .N_SAMPLES(N_SAMPLES), .BIT_WIDTH(BW)
    ) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
        .grant_id(grant_id), .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_REQ-1:0] val;
        logic             rdy;
        logic [BW-1:0]    msg2;
        logic             exp_fa;
        logic             exp_sv;
        logic [N_REQ-1:0] exp_rdy;
        logic [1:0]       exp_gid;
        logic             chk_msg;
    } vec_t;

    vec_t          vecs[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            m_owner, m_beats, m_rr, m_grant;
    int            cyc = 0;
    logic [BW-1:0] exp_q[$];
    int            log_gid[$];
    logic [BW-1:0] log_msg[$];
    int            log_cyc[$];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int scan(input int start, input logic [N_REQ-1:0] v);
        for (int k = 0; k < N_REQ; k++)
            if (v[(start + k) % N_REQ]) return (start + k) % N_REQ;
        return -1;
    endfunction

    function automatic logic [BW-1:0] slot(input int i);
        return recv_msg[i*BW +: BW];
    endfunction

    task automatic rand_msgs();
        for (int i = 0; i < N_REQ; i++) recv_msg[i*BW +: BW] = $urandom;
    endtask

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_rr = 0; m_grant = 0;
        exp_q.delete(); log_gid.delete(); log_msg.delete(); log_cyc.delete();
    endtask

    // Called at posedge+1 with inputs applied; checks outputs at the falling edge.
    task automatic settle_check();
        logic             exp_fa, exp_sv;
        logic [N_REQ-1:0] exp_rdy;
        exp_fa  = (m_owner >= 0);
        exp_sv  = 1'b0;
        exp_rdy = '0;
        if (exp_fa) begin
            exp_sv = recv_val[m_owner];
            if (send_rdy) exp_rdy[m_owner] = 1'b1;
        end
        #4;
        chk("frame_active", frame_active, exp_fa);
        chk("send_val", send_val, exp_sv);
        chk("recv_rdy", recv_rdy, exp_rdy);
        chk("grant_id", grant_id, m_grant);
        if (exp_sv) chk("send_msg", send_msg, slot(m_owner));
        if (exp_sv && send_rdy) exp_q.push_back(slot(m_owner));
        if (send_val && send_rdy) begin
            log_gid.push_back(int'(grant_id));
            log_msg.push_back(send_msg);
            log_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_beat: got 0x%0h expected no transfer (t=%0t)", send_msg, $time);
            end else begin
                chk("sb_data", send_msg, exp_q.pop_front());
            end
        end
    endtask

    // Frame-level reference: who owns the port, how many beats it has moved, where the next scan starts.
    task automatic advance();
        int w;
        @(posedge clk);
        if (m_owner < 0) begin
            w = scan(m_rr, recv_val);
            if (w >= 0) begin m_owner = w; m_grant = w; m_beats = 0; end
        end else if (recv_val[m_owner] && send_rdy) begin
            m_beats++;
            if (m_beats == N_SAMPLES) begin
                m_rr    = (m_owner + 1) % N_REQ;
                m_owner = -1;
`ifdef DESER_ARB_BACK_TO_BACK_EN
                w = scan(m_rr, recv_val);
                if (w >= 0) begin m_owner = w; m_grant = w; m_beats = 0; end
`endif
            end
        end
        cyc++;
        #1;
    endtask

    task automatic cycle();
        settle_check();
        advance();
    endtask

    task automatic do_reset();
        chk("sb_drained", exp_q.size(), 0);
        reset    = 1'b0;
        recv_val = '0;
        send_rdy = 1'b0;
        rand_msgs();
        #1;
        chk("rst_send_val", send_val, 0);
        chk("rst_recv_rdy", recv_rdy, 0);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_send_msg", send_msg, slot(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int order[5];
        order    = '{0, 1, 2, 3, 0};
        reset    = 1'b0;
        recv_val = '0;
        send_rdy = 1'b0;
        recv_msg = '0;
        model_reset();

        // Test 1 vectors: lone requester 2 streams 0x100..0x107.
        vecs.push_back('{4'b0100, 1'b1, 32'h100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0});
        for (int k = 1; k <= N_SAMPLES; k++)
            vecs.push_back('{4'b0100, 1'b1, 32'h100 + k - 1, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1});
`ifdef DESER_ARB_BACK_TO_BACK_EN
        vecs.push_back('{4'b0000, 1'b1, 32'h0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0});
`else
        vecs.push_back('{4'b0000, 1'b1, 32'h0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0});
        vecs.push_back('{4'b1111, 1'b1, 32'h0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0});
        vecs.push_back('{4'b1111, 1'b1, 32'h0, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0});
`endif

        @(posedge clk);
        #1;
        do_reset();

        recv_msg = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            recv_val = vecs[i].val;
            send_rdy = vecs[i].rdy;
            recv_msg[2*BW +: BW] = vecs[i].msg2;
            settle_check();
            chk("t1_frame_active", frame_active, vecs[i].exp_fa);
            chk("t1_send_val", send_val, vecs[i].exp_sv);
            chk("t1_recv_rdy", recv_rdy, vecs[i].exp_rdy);
            chk("t1_grant_id", grant_id, vecs[i].exp_gid);
            if (vecs[i].chk_msg) chk("t1_send_msg", send_msg, vecs[i].msg2);
            advance();
        end

        // Test 2: everyone valid, frames rotate 0,1,2,3,0.
        do_reset();
        recv_val = 4'b1111;
        send_rdy = 1'b1;
        for (int c = 0; c < 100 && log_gid.size() < 5 * N_SAMPLES; c++) begin
            rand_msgs();
            cycle();
        end
        chk("t2_beats", log_gid.size() >= 5 * N_SAMPLES, 1);
        if (log_gid.size() >= 5 * N_SAMPLES)
            for (int f = 0; f < 5; f++)
                for (int j = 0; j < N_SAMPLES; j++)
                    chk("t2_frame_owner", log_gid[f*N_SAMPLES + j], order[f]);

        // Test 3: requester 1 with send_rdy toggling every cycle.
        do_reset();
        recv_val = 4'b0010;
        for (int c = 0; c < 60 && log_msg.size() < N_SAMPLES; c++) begin
            send_rdy = (c % 2 == 0);
            recv_msg[1*BW +: BW] = 32'h200 + log_msg.size();
            cycle();
        end
        recv_val = '0;
        for (int c = 0; c < 3; c++) cycle();
        chk("t3_beats", log_msg.size(), N_SAMPLES);
        for (int j = 0; j < log_msg.size(); j++) begin
            chk("t3_data", log_msg[j], 32'h200 + j);
            chk("t3_owner", log_gid[j], 1);
        end

        // Test 4: owner drops val mid-frame while requester 3 waits.
        do_reset();
        recv_val = 4'b0010;
        send_rdy = 1'b1;
        recv_msg[3*BW +: BW] = 32'hDEAD0003;
        for (int c = 0; c < 20 && log_msg.size() < 4; c++) begin
            recv_msg[1*BW +: BW] = 32'h300 + log_msg.size();
            cycle();
        end
        recv_val = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            settle_check();
            chk("t4_send_val_low", send_val, 0);
            chk("t4_rdy3_low", recv_rdy[3], 0);
            advance();
        end
        recv_val = 4'b1010;
        for (int c = 0; c < 20 && log_msg.size() < N_SAMPLES; c++) begin
            recv_msg[1*BW +: BW] = 32'h300 + log_msg.size();
            cycle();
        end
        chk("t4_beats", log_msg.size(), N_SAMPLES);
        for (int j = 0; j < log_msg.size(); j++) begin
            chk("t4_data", log_msg[j], 32'h300 + j);
            chk("t4_owner", log_gid[j], 1);
        end

        // Test 5: asynchronous reset in the middle of requester 2's frame.
        do_reset();
        recv_val = 4'b0100;
        send_rdy = 1'b1;
        for (int c = 0; c < 20 && log_msg.size() < 5; c++) begin
            recv_msg[2*BW +: BW] = 32'h500 + log_msg.size();
            cycle();
        end
        chk("t5_beats_before_reset", log_msg.size(), 5);
        #1;
        chk("t5_pre_active", frame_active, 1);
        reset = 1'b0;
        #1;
        chk("t5_async_send_val", send_val, 0);
        chk("t5_async_recv_rdy", recv_rdy, 0);
        chk("t5_async_frame_active", frame_active, 0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        recv_val = 4'b0101;
        model_reset();
        cycle();
        settle_check();
        chk("t5_regrant", grant_id, 0);
        chk("t5_regrant_active", frame_active, 1);
        advance();

        // Test 6: requesters 0 and 1 back to back.
        do_reset();
        recv_val = 4'b0011;
        send_rdy = 1'b1;
        for (int c = 0; c < 40 && log_gid.size() < 2 * N_SAMPLES; c++) begin
            rand_msgs();
            cycle();
        end
        chk("t6_beats", log_gid.size() >= 2 * N_SAMPLES, 1);
        if (log_gid.size() >= 2 * N_SAMPLES) begin
            chk("t6_first_owner", log_gid[N_SAMPLES-1], 0);
            chk("t6_second_owner", log_gid[N_SAMPLES], 1);
            chk("t6_frame_gap", log_cyc[N_SAMPLES] - log_cyc[N_SAMPLES-1], FRAME_GAP);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            recv_val = N_REQ'($urandom_range(0, 15));
            send_rdy = ($urandom_range(0, 3) != 0);
            rand_msgs();
            cycle();
        end
        chk("sb_drained_final", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
